// File: rtl/nand_gate_arbiter.sv
// Round-robin arbiter feeding one registered NAND datapath shared by NUM_REQ requesters.
// Results come back one cycle after accept, tagged with the winning requester index.

module nand_gate #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  assign y = ~(a & b);
endmodule

module nand_gate_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_y,
  output logic [ID_W-1:0]            rsp_id
);

  logic [NUM_REQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [ID_W-1:0]               rr_ptr, gnt_idx, idx;
  logic                          gnt_vld, free, accept;
  logic [WIDTH-1:0]              nand_y;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  // First valid index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  assign free      = !rsp_valid || rsp_ready;
  assign accept    = gnt_vld && free && rst_n;
  assign req_ready = accept ? (NUM_REQ'(1) << gnt_idx) : '0;

  nand_gate #(.WIDTH(WIDTH)) u_nand (
    .a (a_arr[gnt_idx]),
    .b (b_arr[gnt_idx]),
    .y (nand_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_y     <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_y     <= nand_y;
      rsp_id    <= gnt_idx;
      rr_ptr    <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nand_gate_arbiter.sv
// Scoreboard bench for nand_gate_arbiter: a behavioural arbiter model predicts req_ready
// and queues expected {id, y} on accept; results are popped and compared when drained.

module tb_nand_gate_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         req_valid, req_ready;
  logic [N-1:0][W-1:0]  ta, tb_;
  logic                 rsp_valid, rsp_ready;
  logic [W-1:0]         rsp_y;
  logic [IW-1:0]        rsp_id;

  typedef struct packed { logic [IW-1:0] id; logic [W-1:0] y; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int m_ptr = 0;
  bit m_vld = 0;
  bit rand_mode = 0;
  logic [W-1:0] hold_y;
  logic [IW-1:0] hold_id;

  always #5 clk = ~clk;

  nand_gate_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(ta), .req_b(tb_), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check at negedge, advance model at posedge, return 1 time unit later.
  task automatic tick();
    bit gv, acc;
    int g, idx;
    logic [N-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    gv = 0; g = 0;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (!gv && req_valid[idx]) begin gv = 1; g = idx; end
    end
    acc = rst_n && gv && (!m_vld || rsp_ready);
    exp_rdy = acc ? (N'(1) << g) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_vld));
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("sb_empty", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_y", 32'(rsp_y), 32'(e.y));
      end
    end
    e.id = IW'(g);
    e.y  = ~(ta[g] & tb_[g]);
    @(posedge clk);
    if (!rst_n) begin
      m_vld = 0; m_ptr = 0; sb.delete();
    end else if (acc) begin
      sb.push_back(e);
      m_vld = 1;
      m_ptr = (g == N-1) ? 0 : g + 1;
    end else if (rsp_ready) m_vld = 0;
    #1;
    if (rand_mode) begin
      if (acc) begin
        ta[g] = W'($urandom); tb_[g] = W'($urandom);
        req_valid[g] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    int seq [6] = '{0, 1, 2, 3, 0, 1};
    rst_n = 0; req_valid = '1; rsp_ready = 1;
    for (int i = 0; i < N; i++) begin ta[i] = W'(8'h11 * (i + 1)); tb_[i] = W'(8'hA5 ^ i); end
    @(posedge clk); #1;

    // Reset held with every request valid
    repeat (3) tick();
    chk("rst_y", 32'(rsp_y), 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    rst_n = 1;
    tick();
    chk("first_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    tick();

    // Single request from requester 2
    ta[2] = 8'hF0; tb_[2] = 8'hCC; req_valid = 4'b0100;
    tick();
    req_valid = '0;
    chk("single_vld", 32'(rsp_valid), 32'h1);
    chk("single_id", 32'(rsp_id), 32'h2);
    chk("single_y", 32'(rsp_y), 32'h3F);
    tick();

    // Move pointer back to 0, then continuous demand
    req_valid = 4'b1000;
    tick();
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_id", 32'(rsp_id), 32'(seq[k]));
      chk("rr_vld", 32'(rsp_valid), 32'h1);
    end

    // Backpressure for 5 cycles
    rsp_ready = 0;
    hold_y = rsp_y; hold_id = rsp_id;
    repeat (5) begin
      tick();
      chk("bp_id", 32'(rsp_id), 32'(hold_id));
      chk("bp_y", 32'(rsp_y), 32'(hold_y));
    end
    rsp_ready = 1;
    tick();
    chk("bp_rel_vld", 32'(rsp_valid), 32'h1);
    chk("bp_rel_id", 32'(rsp_id), 32'h2);

    // Wrap and skip: only 1 and 3 valid
    req_valid = 4'b1010;
    tick();
    chk("wrap_id3", 32'(rsp_id), 32'h3);
    req_valid = 4'b0010;
    tick();
    chk("wrap_id1", 32'(rsp_id), 32'h1);

    // Reset mid-operation (rsp_valid=1, pointer at 2)
    req_valid = '0; rst_n = 0;
    tick();
    chk("mid_rst_vld", 32'(rsp_valid), 32'h0);
    rst_n = 1; req_valid = '1;
    tick();
    chk("mid_rst_id", 32'(rsp_id), 32'h0);

    // Random traffic
    rand_mode = 1;
    repeat (400) tick();
    rand_mode = 0;
    req_valid = '0; rsp_ready = 1;
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nand_gate_arbiter.md
# nand_gate_arbiter

Round-robin arbiter that shares one registered NAND datapath among NUM_REQ requesters. Each requester offers an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle and computes the bitwise NAND into a single output register. It returns the result with the winning requester's index over a downstream valid/ready handshake. It sits between the stimulus-side agents and a single shared nand_gate instance, and sequences every access to that datapath.

## Interface
Parameters:
- NUM_REQ, default 4: number of requesters, 2..16.
- WIDTH, default 8: operand and result width in bits.
- ID_W, default $clog2(NUM_REQ): width of rsp_id.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high in any cycle.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  output  1  result register holds an undelivered result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_y  output  WIDTH  ~(a & b) of the accepted request.
- rsp_id  output  ID_W  index of the requester that produced rsp_y.

## Operation
- State:
  - rr_ptr (ID_W): highest-priority index for the current cycle.
  - rsp_valid, rsp_y, rsp_id: the output register.
- Arbitration (combinational, every cycle):
  - Scan indices rr_ptr, rr_ptr+1, …, wrapping modulo NUM_REQ.
  - The first index with req_valid high is the grant. No request valid means no grant.
- Slot free: free = !rsp_valid | rsp_ready.
- req_ready[g] = free for the granted index g; every other req_ready bit is 0.
- Accept: req_valid[g] & req_ready[g] at a rising edge. On accept:
  - rsp_y ← ~(req_a[g] & req_b[g]);
  - rsp_id ← g;
  - rsp_valid ← 1;
  - rr_ptr ← (g == NUM_REQ-1) ? 0 : g+1.
- Drain without accept: rsp_valid & rsp_ready and no accept → rsp_valid ← 0. rsp_y and rsp_id hold their values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge, and rsp_valid stays 1. This gives full throughput of one result per cycle.
- Stall (rsp_valid & !rsp_ready):
  - All req_ready are 0.
  - The output register and rr_ptr hold.
  - The grant is still recomputed each cycle, so a newly valid higher-priority requester may take the grant before release.
- rr_ptr changes only on accept, never on stall or idle.
- Requesters must hold req_valid and operands stable until accepted. The arbiter does not check this rule.
- Reset (rst_n low at an edge):
  - rsp_valid=0, rsp_y=0, rsp_id=0, rr_ptr=0.
  - Any in-flight result is discarded.
  - While rst_n is low, req_ready is forced to 0.

## Timing
- Request-to-response latency: 1 cycle. An accept at edge T makes rsp_valid, rsp_y and rsp_id visible after T and hold them until drained.
- Throughput: 1 accept per cycle while rsp_ready=1.
- req_ready combinationally depends on req_valid, rsp_valid, rsp_ready and rr_ptr.
- req_ready has no dependency on req_a or req_b.
- rsp_* are driven only from registers; there is no combinational path from inputs to rsp_*.
- Fairness: under continuous demand from all requesters, each requester waits at most NUM_REQ-1 accepts between its own accepts.
- Reset values: rsp_valid=0, rsp_y=0, rsp_id=0, req_ready=0.

## Test plan
All scenarios use NUM_REQ=4, WIDTH=8.
- Reset: hold rst_n=0 for 3 cycles with all req_valid=1 → req_ready=0000, rsp_valid=0, rsp_y=0x00, rsp_id=0. First accept after release goes to index 0.
- Single request: requester 2 drives a=0xF0, b=0xCC, rsp_ready=1 → req_ready=0100 at edge T; one cycle later rsp_valid=1, rsp_id=2, rsp_y=0x3F.
- Round robin: all four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, with rsp_valid high every cycle.
- Backpressure: rsp_valid=1 with rsp_ready=0 for 5 cycles, requests pending →
  - req_ready=0000 throughout; rsp_y and rsp_id stable;
  - the cycle rsp_ready=1, a new accept occurs and rsp_valid stays 1 with the new rsp_id.
- Wrap and skip: after an accept from 2, only requesters 1 and 3 are valid → accept order is 3 then 1, and rr_ptr wraps from 3 to 0.
- Reset mid-operation: rst_n=0 for one edge while rsp_valid=1 and rr_ptr=2 → next cycle rsp_valid=0, and the next accept starts scanning from index 0.
